// File: rtl/pc_unit.sv
// Program counter with stall, branch, branch-with-link and return, backed by a
// circular return-address stack that reports full/empty and sticky overflow/underflow.
module pc_unit #(
    parameter int                 WIDTH        = 32,
    parameter int                 STEP         = 4,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = '0,
    parameter int                 RAS_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall,
    input  logic                         branch,
    input  logic                         link,
    input  logic [WIDTH-1:0]             branch_target,
    input  logic                         ret,
    input  logic                         err_clr,
    output logic [WIDTH-1:0]             pc,
    output logic [WIDTH-1:0]             pc_plus,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_full,
    output logic                         ras_empty,
    output logic                         ras_ovf,
    output logic                         ras_unf
);

    localparam int               PW     = $clog2(RAS_DEPTH);
    localparam int               CW     = PW + 1;
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    localparam logic [CW-1:0]    DEPTH_C = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PW-1:0]    sp_q, sp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] stack_q [RAS_DEPTH];

    logic             do_push;
    logic             do_pop;
    logic             ret_empty;
    logic [PW-1:0]    top_idx;

    assign pc_plus   = pc_q + STEP_W;
    assign ras_full  = (cnt_q == DEPTH_C);
    assign ras_empty = (cnt_q == '0);
    assign top_idx   = sp_q - PW'(1);

    // A branch always wins over ret, so a coincident ret neither pops nor flags.
    assign do_push   = !stall && branch && link;
    assign do_pop    = !stall && !branch && ret && !ras_empty;
    assign ret_empty = !stall && !branch && ret && ras_empty;

    always_comb begin
        pc_d = pc_plus;
        if (stall)
            pc_d = pc_q;
        else if (branch)
            pc_d = branch_target;
        else if (do_pop)
            pc_d = stack_q[top_idx];

        sp_d  = sp_q;
        cnt_d = cnt_q;
        if (do_push) begin
            sp_d = sp_q + PW'(1);
            if (!ras_full)
                cnt_d = cnt_q + CW'(1);
        end else if (do_pop) begin
            sp_d  = top_idx;
            cnt_d = cnt_q - CW'(1);
        end

        // Setting beats clearing when both happen on the same edge.
        ovf_d = ovf_q;
        if (err_clr)
            ovf_d = 1'b0;
        if (do_push && ras_full)
            ovf_d = 1'b1;

        unf_d = unf_q;
        if (err_clr)
            unf_d = 1'b0;
        if (ret_empty)
            unf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_VECTOR;
            sp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Entry storage needs no reset; a push while full overwrites the oldest slot.
    always_ff @(posedge clk) begin
        if (do_push)
            stack_q[sp_q] <= pc_plus;
    end

    assign pc        = pc_q;
    assign ras_count = cnt_q;
    assign ras_ovf   = ovf_q;
    assign ras_unf   = unf_q;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit replacing the plain 32-bit PC register in the ARM_Calculator datapath.
- Holds the current fetch address and advances it by a fixed step each cycle.
- Supports stall, branch load, branch-with-link, and return.
- Contains a small return-address stack (RAS) for call/return, with full/empty status and sticky overflow/underflow error flags for the control unit.

Parameters:
- WIDTH, 32: PC and address width in bits.
- STEP, 4: increment applied on sequential fetch.
- RESET_VECTOR, 0: PC value loaded on reset.
- RAS_DEPTH, 4: return-address stack entries; power of two, ≥2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  hold PC and RAS unchanged this cycle.
- branch  input  1  load PC from branch_target.
- link  input  1  qualifies branch; push return address (pc+STEP) onto RAS.
- branch_target  input  WIDTH  branch destination address.
- ret  input  1  pop RAS top into PC.
- err_clr  input  1  synchronous clear of the sticky error flags.
- pc  output  WIDTH  current PC, registered.
- pc_plus  output  WIDTH  combinational pc+STEP, mod 2^WIDTH.
- ras_count  output  $clog2(RAS_DEPTH)+1  valid entries, 0..RAS_DEPTH.
- ras_full  output  1  ras_count==RAS_DEPTH.
- ras_empty  output  1  ras_count==0.
- ras_ovf  output  1  sticky: push attempted while full.
- ras_unf  output  1  sticky: pop attempted while empty.

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-operation):
  - pc=RESET_VECTOR; ras_count=0; ras_ovf=0; ras_unf=0; stack pointer=0.
  - Stack contents are don't-care.
  - Reset release takes effect at the next rising edge.
- Per-edge priority: stall > branch > ret > sequential.
  - stall=1: pc, RAS, and flags all hold. err_clr is still honoured.
  - branch=1: pc<=branch_target.
    - If link=1, push pc_plus (value at that edge).
    - A simultaneous ret is ignored: no pop, no error.
  - ret=1 (no branch), ras_count>0: pc<=top entry; ras_count decrements.
  - ret=1, ras_count==0: pc<=pc_plus; ras_unf<=1.
  - Otherwise: pc<=pc_plus.
- Arithmetic: pc_plus=(pc+STEP) mod 2^WIDTH; carry discarded. No alignment masking on branch_target.
- Latency: every load is visible on pc one cycle after the edge that samples the request.
- link without branch has no effect.
- RAS is circular: write pointer advances on push and retreats on pop, modulo RAS_DEPTH.
- Push while full:
  - New entry overwrites the oldest; ras_count stays RAS_DEPTH; ras_ovf<=1.
  - Later pops return the newest RAS_DEPTH addresses in LIFO order.
- Sticky flags: set as above; cleared only by reset or err_clr=1 at an edge.
  - Set and clear at the same edge: set wins.
- ras_full and ras_empty are decoded combinationally from ras_count.

Test Plan:
- Reset/sequential: rst_n low, then release; 3 edges → pc 0x0, 0x4, 0x8, 0xC. Assert rst_n mid-run → pc=0x0 immediately, without waiting for an edge.
- Stall: at pc=0x10, stall=1 with branch=1, target=0x100 for 2 edges → pc stays 0x10, ras_count=0. Release stall → next pc 0x14.
- Call/return: at pc=0x20, branch+link, target=0x200 → pc=0x200, ras_count=1. Two sequential edges → 0x208. ret → pc=0x24, ras_count=0, ras_empty=1.
- Overflow (RAS_DEPTH=4): 5 consecutive branch+link from pc=0x0, 0x100, 0x200, 0x300, 0x400 (each targeting the next) → ras_full=1, ras_ovf=1. 4 rets yield 0x404, 0x304, 0x204, 0x104. 5th ret → pc=0x108, ras_unf=1.
- Wrap and priority: pc=0xFFFFFFFC sequential → pc=0x0. branch and ret together, target=0x40 with 1 entry → pc=0x40, ras_count still 1.
- Flag clear: with ras_unf=1, err_clr=1 one edge → ras_unf=0. err_clr coincident with a new underflow → ras_unf stays 1.
